// File: rtl/arcade_input_ctrl.sv
// Player-input front end: merges PS/2 key events and HPS joystick words into
// registered per-player lines, with autofire, shared control, coin shaping and DIP capture.
module arcade_input_ctrl #(
  parameter int PLAYERS   = 2,
  parameter int DIP_BYTES = 8,
  parameter int COIN_MIN  = 4000000,
  parameter int AF_DIV    = 1333333
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic [10:0]            ps2_key,
  input  logic [16*PLAYERS-1:0]  joy_in,
  input  logic                   ioctl_wr,
  input  logic [7:0]             ioctl_index,
  input  logic [24:0]            ioctl_addr,
  input  logic [7:0]             ioctl_dout,
  input  logic [1:0]             autofire_en,
  input  logic                   shared_ctrl,
  output logic [4*PLAYERS-1:0]   p_dir,
  output logic [2*PLAYERS-1:0]   p_fire,
  output logic [PLAYERS-1:0]     p_start,
  output logic                   coin,
  output logic [8*DIP_BYTES-1:0] dip,
  output logic                   dip_valid
);

  localparam int CW = $clog2(COIN_MIN);
  localparam int AW = $clog2(AF_DIV);

  // ---------------------------------------------------------------- keyboard
  logic            old_tgl;
  logic            key_event;
  logic            key_down;
  logic [1:0][3:0] key_dir;
  logic [1:0][1:0] key_fire;
  logic [1:0]      key_start;
  logic            key_coin;

  assign key_event = (old_tgl != ps2_key[10]);
  assign key_down  = ps2_key[9];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      old_tgl   <= 1'b0;
      key_dir   <= '0;
      key_fire  <= '0;
      key_start <= '0;
      key_coin  <= 1'b0;
    end else begin
      old_tgl <= ps2_key[10];
      if (key_event) begin
        case (ps2_key[7:0])
          8'h75:        key_dir[0][3] <= key_down;
          8'h72:        key_dir[0][2] <= key_down;
          8'h6B:        key_dir[0][1] <= key_down;
          8'h74:        key_dir[0][0] <= key_down;
          8'h14:        key_fire[0][0] <= key_down;
          8'h11:        key_fire[0][1] <= key_down;
          8'h05, 8'h16: key_start[0] <= key_down;
          8'h2D:        if (PLAYERS > 1) key_dir[1][3] <= key_down;
          8'h2B:        if (PLAYERS > 1) key_dir[1][2] <= key_down;
          8'h23:        if (PLAYERS > 1) key_dir[1][1] <= key_down;
          8'h34:        if (PLAYERS > 1) key_dir[1][0] <= key_down;
          8'h1C:        if (PLAYERS > 1) key_fire[1][0] <= key_down;
          8'h1B:        if (PLAYERS > 1) key_fire[1][1] <= key_down;
          8'h06, 8'h1E: if (PLAYERS > 1) key_start[1] <= key_down;
          8'h76, 8'h2E, 8'h36: key_coin <= key_down;
          default: ;
        endcase
      end
    end
  end

  // ------------------------------------------------------- per-player merge
  logic [PLAYERS-1:0][3:0] raw_dir;
  logic [PLAYERS-1:0][1:0] raw_fire;
  logic [PLAYERS-1:0]      raw_start;
  logic [PLAYERS-1:0]      joy_coin;
  logic [PLAYERS-1:0]      unused_joy;

  for (genvar gi = 0; gi < PLAYERS; gi++) begin : g_player
    logic [15:0] joy;
    assign joy = joy_in[16*gi +: 16];
    if (gi < 2) begin : g_kbd
      assign raw_dir[gi]   = joy[3:0] | key_dir[gi];
      assign raw_fire[gi]  = joy[5:4] | key_fire[gi];
      assign raw_start[gi] = joy[6]   | key_start[gi];
    end else begin : g_joy
      assign raw_dir[gi]   = joy[3:0];
      assign raw_fire[gi]  = joy[5:4];
      assign raw_start[gi] = joy[6];
    end
    assign joy_coin[gi]   = joy[8];
    assign unused_joy[gi] = ^{joy[15:9], joy[7]};
  end

  logic unused_ok;
  assign unused_ok = ^{ps2_key[8], unused_joy};

  // ------------------------------------------------------------- autofire
  logic [AW-1:0] af_cnt;
  logic          af_phase;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      af_cnt   <= '0;
      af_phase <= 1'b0;
    end else if (af_cnt == AW'(AF_DIV - 1)) begin
      af_cnt   <= '0;
      af_phase <= ~af_phase;
    end else begin
      af_cnt <= af_cnt + AW'(1);
    end
  end

  // ------------------------------------------------ shared mode and outputs
  logic [3:0]           any_dir;
  logic [1:0]           any_fire;
  logic [1:0]           af_mask;
  logic [4*PLAYERS-1:0] dir_next;
  logic [2*PLAYERS-1:0] fire_next;

  always_comb begin
    any_dir  = '0;
    any_fire = '0;
    for (int p = 0; p < PLAYERS; p++) begin
      any_dir  |= raw_dir[p];
      any_fire |= raw_fire[p];
    end
  end

  // A disabled autofire bit passes fire straight through.
  assign af_mask = ~autofire_en | {2{af_phase}};

  for (genvar gi = 0; gi < PLAYERS; gi++) begin : g_out
    assign dir_next[4*gi +: 4]  = shared_ctrl ? any_dir : raw_dir[gi];
    assign fire_next[2*gi +: 2] = (shared_ctrl ? any_fire : raw_fire[gi]) & af_mask;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      p_dir   <= '0;
      p_fire  <= '0;
      p_start <= '0;
    end else begin
      p_dir   <= dir_next;
      p_fire  <= fire_next;
      p_start <= raw_start;
    end
  end

  // ---------------------------------------------------------- coin shaper
  typedef enum logic [1:0] {C_IDLE, C_PULSE, C_HOLD, C_GAP} coin_state_t;

  coin_state_t state, state_next;
  logic [CW-1:0] ccnt, ccnt_next;
  logic          coin_raw;
  logic          coin_raw_d;

  assign coin_raw = key_coin | (|joy_coin);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= C_IDLE;
      ccnt       <= '0;
      coin_raw_d <= 1'b0;
    end else begin
      state      <= state_next;
      ccnt       <= ccnt_next;
      coin_raw_d <= coin_raw;
    end
  end

  // The edge detector tracks coin_raw in every state, so a level still high
  // when GAP ends is not mistaken for a new insertion.
  always_comb begin
    state_next = state;
    ccnt_next  = ccnt;
    coin       = 1'b0;
    case (state)
      C_IDLE: begin
        if (coin_raw && !coin_raw_d) begin
          state_next = C_PULSE;
          ccnt_next  = CW'(COIN_MIN - 1);
        end
      end
      C_PULSE: begin
        coin = 1'b1;
        if (ccnt == '0) begin
          if (coin_raw) begin
            state_next = C_HOLD;
          end else begin
            state_next = C_GAP;
            ccnt_next  = CW'(COIN_MIN - 1);
          end
        end else begin
          ccnt_next = ccnt - CW'(1);
        end
      end
      C_HOLD: begin
        coin = 1'b1;
        if (!coin_raw) begin
          state_next = C_GAP;
          ccnt_next  = CW'(COIN_MIN - 1);
        end
      end
      C_GAP: begin
        if (ccnt == '0) state_next = C_IDLE;
        else            ccnt_next  = ccnt - CW'(1);
      end
      default: state_next = C_IDLE;
    endcase
  end

  // ---------------------------------------------------------- DIP capture
  logic dip_we;
  assign dip_we = ioctl_wr && (ioctl_index == 8'd254) && (ioctl_addr < 25'(DIP_BYTES));

  for (genvar gi = 0; gi < DIP_BYTES; gi++) begin : g_dip
    logic [7:0] dip_byte;
    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)                                 dip_byte <= '0;
      else if (dip_we && ioctl_addr[2:0] == 3'(gi)) dip_byte <= ioctl_dout;
    end
    assign dip[8*gi +: 8] = dip_byte;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)                                            dip_valid <= 1'b0;
    else if (dip_we && ioctl_addr[2:0] == 3'(DIP_BYTES - 1)) dip_valid <= 1'b1;
  end

endmodule

// File: doc/arcade_input_ctrl.md
# arcade_input_ctrl

Parametrised player-input front end for arcade cores. It merges PS/2 keyboard events and per-player HPS joystick words into registered per-player direction, fire and start lines. It also adds autofire, shared-control mode and a coin-pulse shaper, and it captures the DIP bank from the ioctl stream. It sits between `hps_io` and the game core in each `emu` top level, replacing ad-hoc per-core keyboard and joystick logic.

## Interface
Parameters:
- `PLAYERS`, 2: number of players (1..4); keyboard maps players 0 and 1 only.
- `DIP_BYTES`, 8: number of DIP bytes captured (1..8).
- `COIN_MIN`, 4000000: coin pulse length and minimum gap, in clocks (100 ms at 40 MHz); must be ≥2.
- `AF_DIV`, 1333333: autofire half-period in clocks; must be ≥2.

Ports:
- `clk_sys` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `ps2_key` in 11: [10] event toggle, [9] pressed, [8] extended (ignored), [7:0] scan code.
- `joy_in` in 16*PLAYERS: player p at [16p+15:16p]; bits [0] R, [1] L, [2] D, [3] U, [4] fireA, [5] fireB, [6] start, [8] coin.
- `ioctl_wr` in 1, `ioctl_index` in 8, `ioctl_addr` in 25, `ioctl_dout` in 8: download bus.
- `autofire_en` in 2: [0] fireA, [1] fireB.
- `shared_ctrl` in 1: drive every player from the OR of all players.
- `p_dir` out 4*PLAYERS: per player {U,D,L,R}.
- `p_fire` out 2*PLAYERS: per player {B,A}.
- `p_start` out PLAYERS.
- `coin` out 1: shaped coin pulse.
- `dip` out 8*DIP_BYTES: byte i at [8i+7:8i].
- `dip_valid` out 1.

## Operation
- Keyboard decode:
  - `ps2_key[10]` is registered into `old_tgl`.
  - When `old_tgl != ps2_key[10]`, the latch selected by the code is loaded with `ps2_key[9]`.
  - Player 0: 75 U, 72 D, 6B L, 74 R, 14 fireA, 11 fireB, 05 or 16 start.
  - Player 1: 2D U, 2B D, 23 L, 34 R, 1C fireA, 1B fireB, 06 or 1E start.
  - Coin: 76, 2E, 36.
  - Codes that alias the same latch follow a last-event-wins rule.
  - Player-1 codes are ignored when PLAYERS=1. Unlisted codes are ignored.
- Per-player raw input = key latch OR joystick bits.
- With `shared_ctrl`=1, the direction and fire lines of all players are ORed, and the result drives every player. Starts are never shared.
- Autofire:
  - A free-running counter runs 0..AF_DIV-1; `af_phase` toggles on each wrap.
  - When `autofire_en[b]`=1, each player's fire b output = raw AND `af_phase`. Otherwise the output = raw.
- Coin shaper, driven by `coin_raw` = any coin latch OR any joystick bit 8:
  - IDLE, `coin`=0: a rising edge of `coin_raw` loads the counter and goes to PULSE.
  - PULSE, `coin`=1: hold for COIN_MIN clocks. Then go to HOLD if `coin_raw`=1, else to GAP.
  - HOLD, `coin`=1: stay until `coin_raw`=0, then go to GAP.
  - GAP, `coin`=0: hold for COIN_MIN clocks, then go to IDLE.
  - Rising edges seen in any state other than IDLE are ignored.
  - A level already high on leaving GAP does not retrigger; a fresh edge is required.
- DIP capture:
  - When `ioctl_wr` && `ioctl_index`==254 && `ioctl_addr` < DIP_BYTES, `ioctl_dout` is written to byte `ioctl_addr[2:0]`.
  - Writing byte DIP_BYTES-1 sets `dip_valid`. It stays set until reset; rewrites update the bytes.

## Timing
- Reset (asynchronous assert, synchronous release): all outputs 0, all latches 0, `old_tgl`=0, autofire counter and `af_phase`=0, coin FSM in IDLE.
- A `ps2_key` toggle that is present before edge N loads the latch at edge N; the outputs reflect it at edge N+1 (2-clock latency).
- Joystick to `p_dir`/`p_fire`/`p_start`: 1 clock.
- Coin:
  - `coin` rises 1 clock after `coin_raw` rises (joystick path) or 2 clocks after (keyboard path).
  - `coin` is high for exactly COIN_MIN clocks when `coin_raw` falls first.
- DIP byte and `dip_valid` are visible 1 clock after the `ioctl_wr` cycle.
- Simultaneous key toggle and joystick change: both are reflected, with their respective latencies.
- Reset mid-pulse: `coin` drops asynchronously and the FSM restarts in IDLE.

## Test plan
- Keyboard press and release: after reset, present ps2_key=0x400|0x200|0x75 -> `p_dir[3]`=1 two clocks later. Toggle bit 10 with pressed=0 -> `p_dir[3]`=0.
- Joystick and shared mode: `joy_in[16+4]`=1 with `shared_ctrl`=0 -> `p_fire[2]`=1, `p_fire[0]`=0. Set `shared_ctrl`=1 -> both =1. `joy_in[16+6]`=1 -> only `p_start[1]`=1.
- Autofire: with AF_DIV=4, `autofire_en`=01, and fireA held -> `p_fire[0]` is a 4-high/4-low square wave. With `autofire_en`=00 -> steady 1.
- Coin shaper: with COIN_MIN=10, a 3-clock `joy_in[8]` pulse -> `coin` high exactly 10 clocks. A second edge 5 clocks after `coin` falls is ignored. A 30-clock hold -> `coin` high until `coin_raw` falls, then a 10-clock gap.
- DIP: write bytes 0..7 = 0x11..0x88 at index 254 -> `dip`=0x8877665544332211, `dip_valid` rises after the byte-7 write. Writes at index 1 or address 8 -> no change.
- Reset mid-operation: assert `reset_n`=0 during PULSE -> `coin`, `dip_valid` and all player outputs go to 0 immediately. After release, a new coin edge gives a full COIN_MIN pulse.
